// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        read_in;
  logic        write_in;
  logic [63:0] address_in;
  logic [63:0] write_value_in;
  logic [7:0]  write_mask_in;
  logic [63:0] read_value_out;
  logic        stall_out;
  logic        err_out;

  modport master (
    output read_in, write_in, address_in, write_value_in, write_mask_in,
    input  read_value_out, stall_out, err_out
  );

  modport slave (
    input  read_in, write_in, address_in, write_value_in, write_mask_in,
    output read_value_out, stall_out, err_out
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding 64-bit byte-masked data memory with configurable wait states.
// Optional out-of-range detection is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [63:0]           wdata_q;
  logic [7:0]            mask_q;
  logic                  wr_q;
  logic                  fault_q;
  logic                  request;
  logic                  access;
  logic [63:0]           mem [0:(1<<ADDR_WIDTH)-1];

  assign request       = bus.read_in | bus.write_in;
  assign access        = (state == BUSY) && (count == '0);
  assign bus.stall_out = request && (state != DONE);

`ifdef DMEM_ERR_EN
  logic fault_d;
  assign fault_d = |bus.address_in[63:ADDR_WIDTH+3];
`else
  assign fault_q     = 1'b0;
  assign bus.err_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count              <= '0;
      addr_q             <= '0;
      wdata_q            <= '0;
      mask_q             <= '0;
      wr_q               <= 1'b0;
      bus.read_value_out <= '0;
`ifdef DMEM_ERR_EN
      fault_q            <= 1'b0;
      bus.err_out        <= 1'b0;
`endif
    end else begin
`ifdef DMEM_ERR_EN
      bus.err_out <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (request) begin
            addr_q  <= bus.address_in[ADDR_WIDTH+2:3];
            wdata_q <= bus.write_value_in;
            mask_q  <= bus.write_mask_in;
            wr_q    <= bus.write_in;
            count   <= 4'(WAIT_STATES);
`ifdef DMEM_ERR_EN
            fault_q <= fault_d;
`endif
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - 4'd1;
          end else begin
            if (!wr_q)
              bus.read_value_out <= fault_q ? '0 : mem[addr_q];
`ifdef DMEM_ERR_EN
            bus.err_out <= fault_q;
`endif
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a write dropped by reset never reaches this edge since state clears asynchronously.
  always_ff @(posedge clk) begin
    if (access && wr_q && !fault_q) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (mask_q[i])
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with WAIT_STATES 0, 1 and 15.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0))  dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb [$];
  logic [63:0] mdl [longint];
  logic [63:0] last_rd [3];
  int          ws [3] = '{0, 1, 15};
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [63:0] a, input logic [63:0] v, input logic [7:0] m);
    case (sel)
      0: begin bus0.read_in = rd; bus0.write_in = wr; bus0.address_in = a; bus0.write_value_in = v; bus0.write_mask_in = m; end
      1: begin bus1.read_in = rd; bus1.write_in = wr; bus1.address_in = a; bus1.write_value_in = v; bus1.write_mask_in = m; end
      default: begin bus2.read_in = rd; bus2.write_in = wr; bus2.address_in = a; bus2.write_value_in = v; bus2.write_mask_in = m; end
    endcase
  endtask

  function automatic logic get_stall(input int sel);
    case (sel)
      0:       return bus0.stall_out;
      1:       return bus1.stall_out;
      default: return bus2.stall_out;
    endcase
  endfunction

  function automatic logic [63:0] get_rdata(input int sel);
    case (sel)
      0:       return bus0.read_value_out;
      1:       return bus1.read_value_out;
      default: return bus2.read_value_out;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      0:       return bus0.err_out;
      1:       return bus1.err_out;
      default: return bus2.err_out;
    endcase
  endfunction

  // Reference behaviour: byte-merge into a sparse word map, remember the last completed read.
  task automatic model(input string tag, input int sel, input logic rd, input logic wr,
                       input logic [63:0] a, input logic [63:0] v, input logic [7:0] m);
    exp_t        e;
    logic        fault;
    longint      key;
    logic [63:0] w;
    logic [9:0]  idx;
`ifdef DMEM_ERR_EN
    fault = |a[63:13];
`else
    fault = 1'b0;
`endif
    idx = a[12:3];
    key = longint'(sel) * 4096 + longint'(idx);
    if (wr) begin
      if (!fault) begin
        w = mdl.exists(key) ? mdl[key] : '0;
        for (int i = 0; i < 8; i++)
          if (m[i]) w[8*i +: 8] = v[8*i +: 8];
        mdl[key] = w;
      end
    end else if (rd) begin
      last_rd[sel] = fault ? '0 : (mdl.exists(key) ? mdl[key] : '0);
    end
    e.tag    = tag;
    e.rdata  = last_rd[sel];
    e.err    = fault;
    e.stalls = ws[sel] + 2;
    sb.push_back(e);
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the edge ending DONE.
  task automatic access(input string tag, input int sel, input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] v, input logic [7:0] m);
    int   stalls = 0;
    exp_t e;
    model(tag, sel, rd, wr, a, v, m);
    drive(sel, rd, wr, a, v, m);
    @(negedge clk);
    while (get_stall(sel) === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({e.tag, ".stall_cycles"}, 64'(stalls), 64'(e.stalls));
    check({e.tag, ".rdata"}, get_rdata(sel), e.rdata);
    check({e.tag, ".err_done"}, 64'(get_err(sel)), 64'(e.err));
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, '0, '0, '0);
    check({e.tag, ".err_after"}, 64'(get_err(sel)), 64'(0));
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 1'b0, '0, '0, '0);
      last_rd[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset%0d.rdata", s), get_rdata(s), 64'h0);
      check($sformatf("reset%0d.err", s), 64'(get_err(s)), 64'h0);
      check($sformatf("reset%0d.stall", s), 64'(get_stall(s)), 64'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    access("wr_full",  1, 1'b0, 1'b1, 64'h10, 64'h0123456789ABCDEF, 8'hFF);
    access("rd_full",  1, 1'b1, 1'b0, 64'h10, '0, 8'h00);
    access("wr_merge", 1, 1'b0, 1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81);
    access("rd_merge", 1, 1'b1, 1'b0, 64'h10, '0, 8'h00);
    access("wr_mask0", 1, 1'b0, 1'b1, 64'h10, 64'h0, 8'h00);
    access("rd_mask0", 1, 1'b1, 1'b0, 64'h10, '0, 8'h00);

    access("ws0_wr",  0, 1'b0, 1'b1, 64'h40, 64'hDEADBEEFCAFEF00D, 8'hFF);
    access("ws0_rd",  0, 1'b1, 1'b0, 64'h40, '0, 8'h00);
    access("ws15_wr", 2, 1'b0, 1'b1, 64'h48, 64'h1122334455667788, 8'hFF);
    access("ws15_rd", 2, 1'b1, 1'b0, 64'h48, '0, 8'h00);

    access("coll_rw", 1, 1'b1, 1'b1, 64'h8, 64'h7, 8'hFF);
    access("coll_rd", 1, 1'b1, 1'b0, 64'h8, '0, 8'h00);

    // Reset while the write to 0x20 is in BUSY: write dropped, read data cleared.
    access("rst_pre", 1, 1'b0, 1'b1, 64'h20, 64'h55, 8'hFF);
    drive(1, 1'b0, 1'b1, 64'h20, 64'hAA, 8'hFF);
    @(negedge clk);
    check("rst.stall_c0", 64'(get_stall(1)), 64'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst.rdata", get_rdata(1), 64'h0);
    check("rst.err", 64'(get_err(1)), 64'h0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("rst.stall_idle", 64'(get_stall(1)), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    access("rst_rd", 1, 1'b1, 1'b0, 64'h20, '0, 8'h00);

    access("oor_wr0",  1, 1'b0, 1'b1, 64'h0,    64'hA5A5A5A5A5A5A5A5, 8'hFF);
    access("oor_wr",   1, 1'b0, 1'b1, 64'h2000, 64'h5A5A5A5A12345678, 8'hFF);
    access("oor_rd",   1, 1'b1, 1'b0, 64'h2000, '0, 8'h00);
    access("oor_rd0",  1, 1'b1, 1'b0, 64'h0,    '0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the CPU's MEM stage: the slave end of the `data_read`/`data_write`/`data_write_mask`/`data_address` request interface. It accepts one 64-bit byte-masked read or write at a time and services it from an internal synchronous word array after a configurable number of wait states. While the access is outstanding it holds the pipeline with `stall_out`. It sits between the MEM stage and the SoC's on-chip data RAM.

## Interface

Parameters:
- `ADDR_WIDTH`, default 10: word-index bits. Depth is 2^ADDR_WIDTH 64-bit words.
- `WAIT_STATES`, default 1: extra BUSY cycles before the array access. Legal range 0..15.

Ports:
- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `read_in` input 1: read request. Held stable by the requester while `stall_out`=1.
- `write_in` input 1: write request. Held stable by the requester while `stall_out`=1.
- `address_in` input 64: byte address. Word index is `address_in[ADDR_WIDTH+2:3]`; bits [2:0] are ignored.
- `write_value_in` input 64: write data. Byte i is bits [8i+7:8i].
- `write_mask_in` input 8: byte enables. Bit i enables byte i.
- `read_value_out` output 64: registered read data. Holds the last completed read.
- `stall_out` output 1: combinational. High while a presented request has not yet reached completion.
- `err_out` output 1: out-of-range access flag, registered. Tied 0 unless `DMEM_ERR_EN` is defined.

## Operation

- A request is present when `read_in | write_in` = 1. If both are high, the access is treated as a write, and `read_value_out` is not updated.
- The FSM has three states: IDLE, BUSY, DONE.
  - IDLE, request present: latch address, write value, mask and type; load counter with `WAIT_STATES`; go to BUSY.
  - IDLE, no request: stay in IDLE.
  - BUSY, counter ≠ 0: decrement the counter.
  - BUSY, counter = 0: perform the access and go to DONE.
    - Write: update only the bytes whose mask bit is set. Mask 0 completes as a no-op with normal timing.
    - Read: capture the full array word into `read_value_out`.
  - DONE: go unconditionally to IDLE. A request seen in the following IDLE cycle is a new access.
- `stall_out` = request present AND state ≠ DONE.
- All accesses use the latched copies. Changes to the inputs after acceptance are ignored.
- Without `DMEM_ERR_EN`, address bits above `ADDR_WIDTH+2` are ignored, so addresses wrap modulo the depth.
- The array is not reset. Contents survive `reset`.

## Timing

- Reset values: state IDLE, counter 0, `read_value_out` 0, `err_out` 0. `stall_out` follows the request inputs combinationally (high if a request is present in IDLE).
- Request first presented in IDLE at cycle 0:
  - BUSY occupies cycles 1 .. 1+WAIT_STATES.
  - The array access happens at the edge ending cycle 1+WAIT_STATES.
  - DONE occurs in cycle 2+WAIT_STATES. `stall_out` is low in that cycle, and `read_value_out` is already valid.
- `stall_out` is high for WAIT_STATES+2 cycles per access. The requester advances at the edge ending DONE.
- Minimum spacing between back-to-back accesses is WAIT_STATES+3 cycles, because DONE always returns through IDLE.
- Reset asserted mid-access (BUSY or DONE): the FSM returns to IDLE immediately. A pending write that has not reached the access edge is dropped. `read_value_out` goes to 0.
- `err_out` is high only during the DONE cycle of a faulting access; otherwise it is 0.

## Configuration

- `DMEM_ERR_EN` defined:
  - An access with any of `address_in[63:ADDR_WIDTH+3]` nonzero is out of range.
  - Timing is unchanged.
  - A faulting write is suppressed.
  - A faulting read loads `read_value_out` with 0.
  - `err_out` pulses for one cycle in DONE.
- `DMEM_ERR_EN` undefined:
  - There is no range check; addresses wrap.
  - `err_out` is constant 0.

## Test plan

- **Full write then read.** Stimulus, WAIT_STATES=1: write addr 0x10, value 0x0123456789ABCDEF, mask 0xFF; then read addr 0x10. Required: `read_value_out` = 0x0123456789ABCDEF in the read's DONE cycle; each access stalls 3 cycles.
- **Byte merge.** Stimulus: addr 0x10 holds 0x0123456789ABCDEF; write value 0xFFFF_FFFF_FFFF_FFFF, mask 0x81. Required: read of 0x10 returns 0xFF23456789ABCDFF. Then write with mask 0x00; required: word unchanged and stall count still 3.
- **Latency sweep.** Stimulus: WAIT_STATES = 0, 1 and 15. Required: `stall_out` high for exactly 2, 3 and 17 cycles; DONE in cycle 2, 3 and 17.
- **Reset mid-access.** Stimulus: write 0xAA to addr 0x20 (previously 0x55, mask 0xFF); assert `reset` in cycle 1 (BUSY). Required: FSM in IDLE; `read_value_out`=0; a later read of 0x20 returns 0x55.
- **Read/write collision.** Stimulus: `read_in`=`write_in`=1, addr 0x8, value 7, mask 0xFF. Required: treated as a write; `read_value_out` unchanged; a later read of 0x8 returns 7.
- **Out of range.** Stimulus, with `DMEM_ERR_EN`, ADDR_WIDTH=10: write then read addr 0x2000 (bit 13 set). Required: `err_out`=1 only in each DONE cycle; write suppressed; read returns 0. Without the macro, the same sequence reads back the written data from word 0 (aliasing).
